// File: rtl/xpb_reduce_seq_if.sv
// Handshake and data bundle between the xpb reduction sequencer,
// its requester, and the xpb table bank.
interface xpb_reduce_seq_if #(
    parameter int NUM_SEG = 8,
    parameter int SEG_W   = 5,
    parameter int DATA_W  = 1024
);
    localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int ACC_W = DATA_W + $clog2(NUM_SEG) + 1;

    logic                     start;
    logic [NUM_SEG*SEG_W-1:0] digits_in;
    logic                     busy;
    logic [SEG_W-1:0]         xpb_idx;
    logic [SEL_W-1:0]         xpb_sel;
    logic                     xpb_req;
    logic [DATA_W-1:0]        xpb_data;
    logic [ACC_W-1:0]         sum_out;
    logic                     done;

    modport master (
        output start, digits_in, xpb_data,
        input  busy, xpb_idx, xpb_sel, xpb_req, sum_out, done
    );

    modport slave (
        input  start, digits_in, xpb_data,
        output busy, xpb_idx, xpb_sel, xpb_req, sum_out, done
    );
endinterface

// File: rtl/xpb_reduce_seq.sv
// Walks the upper-digit segments through the xpb table bank one per
// cycle and sums the returned entries into a non-wrapping accumulator.
module xpb_reduce_seq #(
    parameter int NUM_SEG = 8,
    parameter int SEG_W   = 5,
    parameter int DATA_W  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    xpb_reduce_seq_if.slave    bus
);
    localparam int SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int ACC_W = DATA_W + $clog2(NUM_SEG) + 1;
    localparam int DIG_W = NUM_SEG * SEG_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [SEL_W-1:0]  seg_q, seg_d;
    logic [SEL_W-1:0]  seg_nx;
    logic              req_q, req_d;
    logic [SEG_W-1:0]  idx_q, idx_d;
    logic              vld_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              accept;

    always_comb begin
        accept  = bus.start && (state_q == IDLE || state_q == DONE);
        seg_nx  = seg_q + SEL_W'(1);
        state_d = state_q;
        dig_d   = dig_q;
        seg_d   = seg_q;
        req_d   = 1'b0;
        idx_d   = '0;
        acc_d   = acc_q;

        // Table output is only meaningful one cycle after a request
        if (vld_q) begin
            acc_d = acc_q + ACC_W'(bus.xpb_data);
        end

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = ISSUE;
                    dig_d   = bus.digits_in;
                    seg_d   = '0;
                    req_d   = 1'b1;
                    idx_d   = bus.digits_in[SEG_W-1:0];
                    acc_d   = '0;
                end
            end
            ISSUE: begin
                if (seg_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    seg_d = seg_nx;
                    req_d = 1'b1;
                    idx_d = dig_q[seg_nx*SEG_W +: SEG_W];
                end
            end
            DRAIN: begin
                if (vld_q) begin
                    state_d = DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dig_q   <= '0;
            seg_q   <= '0;
            req_q   <= 1'b0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            vld_q   <= req_q;
            acc_q   <= acc_d;
        end
    end

    assign bus.busy    = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done    = (state_q == DONE);
    assign bus.xpb_req = req_q;
    assign bus.xpb_sel = seg_q;
    assign bus.xpb_idx = idx_q;
    assign bus.sum_out = acc_q;
endmodule
